// File: rtl/bcd_down_counter_if.sv
// Control and status bundle for the BCD countdown timer.
// The controller side (master) drives the load/enable inputs; the counter (slave) returns status.
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic [4*DIGITS-1:0]   c;
    logic                  zero;
    logic                  done;
    logic                  load_err;

    modport master (
        output load, load_val, en,
        input  c, zero, done, load_err
    );

    modport slave (
        input  load, load_val, en,
        output c, zero, done, load_err
    );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with load validation, terminal-count pulse
// and optional automatic reload of the last accepted start value.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | holding the count (any value, including 0); EN is ignored
//   RUN   | decrementing once per enabled edge
module bcd_down_counter #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    bcd_down_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [W-1:0]    count;
    logic [W-1:0]    reload;
    logic [W-1:0]    dec_val;
    logic            done_q;
    logic            err_q;
    logic            load_ok;
    logic            is_zero;
    logic            is_one;

    // A load is accepted only if every nibble of the start value is a decimal digit.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Ripple-borrow BCD decrement: a digit steps down only while all lower digits are 0.
    always_comb begin
        logic borrow;
        borrow  = 1'b1;
        dec_val = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count == W'(1));

    // Sequencer: reset beats load beats count-enable; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            reload <= '0;
            state  <= IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    count  <= bus.load_val;
                    reload <= bus.load_val;
                    state  <= (bus.load_val != '0) ? RUN : IDLE;
                end else begin
                    err_q  <= 1'b1;
                end
            end else if (state == RUN && bus.en) begin
                if (is_zero) begin
                    // Only reachable with auto-reload: the zero has been shown for one cycle.
                    if (AUTO_RELOAD) begin
                        count <= reload;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    count <= dec_val;
                    if (is_one) begin
                        done_q <= 1'b1;
                        if (!AUTO_RELOAD) begin
                            state <= IDLE;
                        end
                    end
                end
            end
        end
    end

    assign bus.c        = count;
    assign bus.zero     = is_zero;
    assign bus.done     = done_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_down_counter.sv
// Randomised scoreboard bench: one counter without and one with auto-reload,
// both driven by the same stimulus and checked against an integer-arithmetic model.
module tb_bcd_down_counter;
    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] c;
        logic         zero;
        logic         done;
        logic         err;
    } exp_t;

    logic clk;
    logic reset;

    bcd_down_counter_if #(.DIGITS(DIGITS)) bus0 ();
    bcd_down_counter_if #(.DIGITS(DIGITS)) bus1 ();

    bcd_down_counter #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    bcd_down_counter #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    // Reference model state, index 0 = stop at zero, index 1 = auto-reload.
    int m_cnt[2];
    int m_rel[2];
    bit m_run[2];
    bit m_done[2];
    bit m_err[2];

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_valid(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] v);
        int r;
        int scale;
        r = 0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r = r + int'(v[4*i +: 4]) * scale;
            scale = scale * 10;
        end
        return r;
    endfunction

    task automatic model_edge(input int k, input bit rst, input bit ld,
                              input logic [W-1:0] lv, input bit en);
        m_done[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (rst) begin
            m_cnt[k] = 0;
            m_rel[k] = 0;
            m_run[k] = 1'b0;
        end else if (ld) begin
            if (bcd_valid(lv)) begin
                m_cnt[k] = from_bcd(lv);
                m_rel[k] = m_cnt[k];
                m_run[k] = (m_cnt[k] != 0);
            end else begin
                m_err[k] = 1'b1;
            end
        end else if (m_run[k] && en) begin
            if (m_cnt[k] == 0) begin
                m_cnt[k] = m_rel[k];
            end else begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin
                    m_done[k] = 1'b1;
                    if (k == 0) m_run[k] = 1'b0;
                end
            end
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.c    = to_bcd(m_cnt[k]);
        e.zero = (m_cnt[k] == 0);
        e.done = m_done[k];
        e.err  = m_err[k];
        return e;
    endfunction

    // Drive one cycle of stimulus on the falling edge, then record the expected post-edge outputs.
    task automatic step(input bit rst, input bit ld, input logic [W-1:0] lv, input bit en);
        @(negedge clk);
        reset         = rst;
        bus0.load     = ld;
        bus0.load_val = lv;
        bus0.en       = en;
        bus1.load     = ld;
        bus1.load_val = lv;
        bus1.en       = en;
        @(posedge clk);
        model_edge(0, rst, ld, lv, en);
        model_edge(1, rst, ld, lv, en);
        exp_q0.push_back(model_out(0));
        exp_q1.push_back(model_out(1));
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one output set per clock from each counter, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("ar0_c",        int'(bus0.c),        int'(e.c));
                check("ar0_zero",     int'(bus0.zero),     int'(e.zero));
                check("ar0_done",     int'(bus0.done),     int'(e.done));
                check("ar0_load_err", int'(bus0.load_err), int'(e.err));
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("ar1_c",        int'(bus1.c),        int'(e.c));
                check("ar1_zero",     int'(bus1.zero),     int'(e.zero));
                check("ar1_done",     int'(bus1.done),     int'(e.done));
                check("ar1_load_err", int'(bus1.load_err), int'(e.err));
            end
        end
    end

    initial begin
        logic [W-1:0] lv;
        bit ld;
        bit en;
        bit rst;
        compared   = 0;
        mismatched = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end
        reset = 1'b1;
        bus0.load = 1'b0; bus0.load_val = '0; bus0.en = 1'b0;
        bus1.load = 1'b0; bus1.load_val = '0; bus1.en = 1'b0;

        // Reset with load/enable toggling.
        step(1'b1, 1'b1, 8'h55, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h12, 1'b1);

        // Load 25 and count across the tens borrow.
        step(1'b0, 1'b1, 8'h25, 1'b0);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Count 03 down to 00, then hold with enable asserted.
        step(1'b0, 1'b1, 8'h03, 1'b1);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Rejected load leaves a running count untouched.
        step(1'b0, 1'b1, 8'h17, 1'b0);
        step(1'b0, 1'b1, 8'h3A, 1'b1);
        step(1'b0, 1'b1, 8'hA3, 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Load wins over enable on the same edge.
        step(1'b0, 1'b1, 8'h40, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Short reload loop, then reset mid-run.
        step(1'b0, 1'b1, 8'h02, 1'b1);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Load of zero goes idle; 99 counts across both digits.
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h99, 1'b1);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic biased toward short counts so terminal events occur often.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 14) == 0);
            en  = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) lv = W'($urandom);
            else if ($urandom_range(0, 1) == 0) lv = to_bcd(int'($urandom_range(0, 12)));
            else lv = to_bcd(int'($urandom_range(0, 99)));
            step(rst, ld, lv, en);
        end

        // Drain: the monitor must have consumed every expectation within a short bound.
        repeat (3) @(posedge clk);
        #2;
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
